// File: rtl/bcd_pkg.sv
// Purpose: shared constants, state encoding and digit check for the BCD-to-binary converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // A nibble is a legal decimal digit only in the range 0..9.
  function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/mul10_add.sv
// Purpose: combinational acc*10 + digit step, built from two shifts and adds, truncated to WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [BCD_W-1:0] d,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_x8;
  logic [WIDTH-1:0] a_x2;

  assign a_x8 = a << 3;
  assign a_x2 = a << 1;

  // Sum wraps modulo 2^WIDTH by construction of the operand widths.
  assign y = a_x8 + a_x2 + WIDTH'(d);

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Purpose: serial packed-BCD to binary converter, one digit per clock, MSD first; invalid-digit check under BCD_DIGIT_CHECK_EN.
// Latency: done pulses DIGITS cycles after the accepting edge; one conversion per DIGITS+1 cycles.
// Backpressure: start is only sampled while busy=0; requests while busy are dropped, not queued.
module bcd_to_bin_conv
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BCD_W*DIGITS-1:0]   bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          bin_out,
  output logic                      err
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  state_t                    state;
  state_t                    state_next;
  logic                      accept;
  logic                      last;
  logic [WIDTH-1:0]          acc;
  logic [WIDTH-1:0]          acc_next;
  logic [WIDTH-1:0]          result;
  logic [BCD_W*DIGITS-1:0]   sr;
  logic [CNT_W-1:0]          cnt;
  logic [BCD_W-1:0]          digit;

  assign digit = sr[BCD_W*DIGITS-1 -: BCD_W];

  mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
    .a (acc),
    .d (digit),
    .y (acc_next)
  );

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode: accept in IDLE, return to IDLE after the last digit.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture digits on accept, fold one digit per edge, publish only the final value.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sr      <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bin_out <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sr  <= bcd_in;
        acc <= '0;
        cnt <= CNT_W'(DIGITS);
      end else if (state == CONV) begin
        acc <= acc_next;
        sr  <= sr << BCD_W;
        cnt <= cnt - CNT_W'(1);
        if (last) begin
          bin_out <= result;
          done    <= 1'b1;
        end
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic flag;
  logic flag_next;

  assign flag_next = flag | ~bcd_digit_valid(digit);
  assign result    = flag_next ? '0 : acc_next;

  // Sticky invalid-digit tracking; err is published alongside bin_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
      err  <= 1'b0;
    end else if (accept) begin
      flag <= 1'b0;
    end else if (state == CONV) begin
      flag <= flag_next;
      if (last) err <= flag_next;
    end
  end
`else
  // Without the check, nibbles 10..15 simply contribute their numeric value.
  assign result = acc_next;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Purpose: self-checking bench for bcd_to_bin_conv (WIDTH=10 and WIDTH=8 instances in parallel).
// Latency: expects done exactly DIGITS cycles after each accepting edge.
// Backpressure: drives starts while busy and checks they are dropped.
module tb_bcd_to_bin_conv;

  typedef struct {
    int bin;
    int err;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy, done, err;
  logic [9:0]  bin_out;
  logic        busy8, done8, err8;
  logic [7:0]  bin_out8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q10[$];
  exp_t q8[$];

  bcd_to_bin_conv #(.DIGITS(3), .WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  bcd_to_bin_conv #(.DIGITS(3), .WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy8), .done(done8), .bin_out(bin_out8), .err(err8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just before the accepting edge: done must appear 4 cycles from now.
  task automatic expect_conv(input int v, input int e);
    q10.push_back('{v, e, cyc + 4});
    q8.push_back('{v % 256, e, cyc + 4});
  endtask

  // Scoreboard for the WIDTH=10 instance.
  always @(negedge clk) begin
    if (done) begin
      check("done_expected_w10", 32'(q10.size() != 0), 32'd1);
      if (q10.size() != 0) begin
        exp_t e;
        e = q10.pop_front();
        check("bin_out_w10", 32'(bin_out), 32'(e.bin));
        check("err_w10", 32'(err), 32'(e.err));
        check("done_cycle_w10", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Scoreboard for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (done8) begin
      check("done_expected_w8", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        check("bin_out_w8", 32'(bin_out8), 32'(e.bin));
        check("err_w8", 32'(err8), 32'(e.err));
        check("done_cycle_w8", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 12'h000;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy_w8", 32'(busy8), 32'd0);
    rst = 1'b0;
    step();

    // 123: busy for exactly three cycles, then done.
    bcd_in = 12'h123;
    start  = 1'b1;
    expect_conv(123, 0);
    step();
    start  = 1'b0;
    bcd_in = 12'h000;
    for (int i = 0; i < 3; i++) begin
      check("busy_during_conv", 32'(busy), 32'd1);
      if (i < 2) step();
    end
    step();
    check("busy_after_conv", 32'(busy), 32'd0);
    repeat (2) step();

    // 999 then 000 back-to-back with start held through the done cycle.
    bcd_in = 12'h999;
    start  = 1'b1;
    expect_conv(999, 0);
    step();
    bcd_in = 12'h000;
    repeat (3) step();
    check("b2b_busy_in_done_cycle", 32'(busy), 32'd0);
    expect_conv(0, 0);
    step();
    start = 1'b0;
    repeat (5) step();

    // Start during busy is dropped; input changes after accept are ignored.
    bcd_in = 12'h456;
    start  = 1'b1;
    expect_conv(456, 0);
    step();
    start  = 1'b0;
    bcd_in = 12'h789;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();

    // Reset on the second conversion edge of 321 aborts it.
    bcd_in = 12'h321;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bin_out", 32'(bin_out), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_bin_out_w8", 32'(bin_out8), 32'd0);
    repeat (6) step();
    bcd_in = 12'h042;
    start  = 1'b1;
    expect_conv(42, 0);
    step();
    start = 1'b0;
    repeat (5) step();

    // Invalid nibble A in the middle digit.
    bcd_in = 12'h1A5;
    start  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
    expect_conv(0, 1);
`else
    expect_conv(205, 0);
`endif
    step();
    start = 1'b0;
    repeat (5) step();

    // A clean conversion afterwards clears err.
    bcd_in = 12'h015;
    start  = 1'b1;
    expect_conv(15, 0);
    step();
    start = 1'b0;
    repeat (6) step();

    check("pending_w10", 32'(q10.size()), 32'd0);
    check("pending_w8", 32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_conv.md
Name: bcd_to_bin_conv

Overview:
Serial packed-BCD to binary converter. It is the inverse of the divide-by-10 digit split that feeds the 7-segment decoders. It turns DIGITS decimal digits (e.g. operator-entered via BTN, or a BCD readout) back into an unsigned binary value, processing one digit per clock, most significant digit first. It uses a start/busy/done handshake, like the other arithmetic engines in the processing system.

Parameters:
DIGITS, 3, number of 4-bit BCD digits in bcd_in (1..8).
WIDTH, 10, bin_out width. Results are reduced modulo 2^WIDTH. WIDTH >= ceil(log2(10^DIGITS)) guarantees exact results.

Ports:
clk  input  1  system clock; all state changes on posedge clk.
rst  input  1  reset, synchronous and active-high; takes effect only on posedge clk.
start  input  1  request; sampled only while busy=0.
bcd_in  input  4*DIGITS  packed BCD; [4*DIGITS-1 -: 4] is the most significant digit. Captured on the accepting edge.
busy  output  1  conversion in progress.
done  output  1  one-cycle pulse; bin_out valid.
bin_out  output  WIDTH  result; held from done until the next done.
err  output  1  invalid-digit flag (see Optional Feature); held like bin_out.

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; busy=0, done=0, bin_out=0, err=0; acc, digit shift register and counter cleared.
  - Reset mid-conversion aborts it; no done is ever produced for the aborted request.
- States:
  - IDLE: busy=0.
  - CONV: busy=1.
  - done is a registered pulse, not a state.
- IDLE -> CONV: on edge E0 with start=1.
  - Latch bcd_in into the shift register; acc<=0; cnt<=DIGITS; busy<=1.
  - done<=0 on every edge unless set below.
- CONV, each edge E1..E_DIGITS:
  - acc <= (acc*10 + d) mod 2^WIDTH, where d = top digit of the shift register.
  - Shift register shifts left 4 bits; cnt<=cnt-1.
  - Multiply by 10 is computed as (acc<<3)+(acc<<1). No multiplier primitive is used.
- Final edge E_DIGITS (cnt==1):
  - bin_out<=final acc value; done<=1; busy<=0; state<=IDLE.
- Latency: done is high in the cycle following E_DIGITS, i.e. DIGITS cycles after the accept edge E0. Throughput is one conversion per DIGITS+1 cycles.
- start while busy=1 is ignored and not queued.
- start high during the done cycle (busy=0) is accepted, giving back-to-back operation.
- bcd_in changes after E0 have no effect on the current conversion.
- Intermediate acc values never appear on bin_out.
- Overflow (WIDTH too small) wraps silently. No flag is raised.

Optional Feature:
Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - Each consumed digit is checked for d > 9.
  - Any invalid digit sets a sticky internal flag, cleared at accept.
  - At E_DIGITS, err<=flag. If the flag is set, bin_out<=0 instead of the acc value. done still pulses normally.
- Undefined:
  - err is tied to 0.
  - Digits 10..15 are used arithmetically as-is (e.g. nibble A contributes 10).

Decomposition:
- Package bcd_pkg holds:
  - localparam BCD_W=4;
  - BCD_MAX=9;
  - state encoding IDLE=1'b0, CONV=1'b1;
  - a function bcd_digit_valid(d).
- One sub-module is natural: mul10_add (combinational, WIDTH-parameterised). Output is (a<<3)+(a<<1)+d truncated to WIDTH. The top block instantiates it once.

Test Plan:
1. DIGITS=3, WIDTH=10; start with bcd_in=12'h123 -> busy high 3 cycles; done pulse 3 cycles after accept; bin_out=10'd123; err=0.
2. bcd_in=12'h999, then 12'h000 back-to-back (start held through the done cycle) -> bin_out=999, then 0; two done pulses 4 cycles apart.
3. start pulsed mid-conversion of 12'h456 with bcd_in=12'h789 -> ignored; single done with bin_out=456.
4. Reset asserted on the 2nd CONV edge of 12'h321 -> no done; busy=0, bin_out=0, err=0; next start 12'h042 -> bin_out=42.
5. WIDTH=8, bcd_in=12'h999 -> bin_out=8'd231 (999 mod 256), err=0.
6. BCD_DIGIT_CHECK_EN defined, bcd_in=12'h1A5 -> done pulses, err=1, bin_out=0. Then 12'h015 -> err=0, bin_out=15. With the macro undefined, 12'h1A5 -> bin_out=205, err=0.
